stream_mux_nx1: RTL and testbench
=================================

# stream_mux_nx1

Parametrised N-to-1 stream multiplexer with valid/ready handshakes and a registered output stage; the successor to the combinational 4x1 MUX. It selects one of CHANNELS input streams, either by an explicit select or by round-robin arbitration, and holds the chosen word in an output register until the consumer accepts it. It sits between multiple producers and a single downstream consumer.

## Interface
- WIDTH, 4, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, $clog2(CHANNELS), select/channel-index width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle
- sel  input  SEL_W  channel select in fixed mode
- mode  input  1  0 = fixed select, 1 = round-robin
- out_data  output  WIDTH  registered data
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts the word
- out_ch  output  SEL_W  index of the channel that supplied out_data

## Operation
- One-entry output register; accept = !out_valid || out_ready.
- Grant, fixed mode: channel sel when sel < CHANNELS and in_valid[sel]; otherwise no grant. sel out of range means no grant and all in_ready low.
- Grant, round-robin mode: the first valid channel searching from rr_ptr+1 upward, wrapping modulo CHANNELS. With no valid channel, there is no grant.
- in_ready[g] = accept for the granted channel g; all other bits are 0. in_ready is combinational from in_valid, sel, mode, rr_ptr and out_ready.
- Transfer: in_valid[g] && in_ready[g]. On the next edge out_data gets channel g's data, out_ch gets g and out_valid gets 1.
- Drain without refill: out_valid && out_ready with no transfer clears out_valid. out_data and out_ch hold their values.
- Simultaneous drain and refill in one cycle is allowed, giving 1 word/cycle throughput.
- rr_ptr updates to g only on a transfer in round-robin mode. It is unchanged in fixed mode.
- mode or sel changes take effect in the same cycle. A word already in the output register is unaffected.
- While out_valid && !out_ready, out_data and out_ch are stable.

## Timing
- Latency: input transfer to out_valid is 1 cycle.
- Reset values: out_valid 0, out_data 0, out_ch 0, rr_ptr CHANNELS-1 (channel 0 has first priority). in_ready is 0 during reset.
- Reset mid-operation drops any held word immediately (asynchronous).
- Producers must hold in_data and in_valid until in_ready. Consumers see out_valid drop only after out_ready.

## Configuration
- STREAM_MUX_RR_EN defined: round-robin logic is compiled in and mode selects the behaviour.
- Not defined: only fixed select exists, the mode port remains but is ignored, and rr_ptr is not implemented.

## Structure
- Package stream_mux_pkg: mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1, plus a function for channel-slice extraction.
- Sub-module rr_arbiter (CHANNELS parameter): request vector and pointer in, one-hot grant and index out. It is instantiated only under STREAM_MUX_RR_EN.

## Test plan
- Fixed mode, data A=0000, B=1001, C=0011, D=1000, all valid, out_ready=1, sel stepping 0,1,2,3 -> out_data 0000, 1001, 0011, 1000 one cycle after each step, with out_ch matching sel.
- Round-robin mode, all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with one in_ready bit high per cycle.
- Backpressure: out_ready=0 for 3 cycles after a word from channel 1 (1001) -> out_data stays 1001, out_valid stays 1 and all in_ready are 0. Releasing out_ready then drains the word and refills in the same cycle.
- Sparse round-robin: only channels 0 and 2 valid -> grants alternate 0,2,0,2, and channels 1 and 3 are never granted.
- Fixed mode with sel=2 and in_valid[2]=0 (others valid) -> no grant, and out_valid clears after the pending word drains.
- Assert rst_n=0 while out_valid=1 -> out_valid, out_data and out_ch are 0 immediately. After release the first round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_nx1 block.
// Provides the mode encodings and a helper that extracts one channel's word
// from a packed multi-channel bus.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds for the slice helper: up to 16 channels of up to 64 bits.
  localparam int MAX_W   = 64;
  localparam int MAX_CH  = 16;
  localparam int MAX_BUS = MAX_W * MAX_CH;

  // Returns the word of channel idx (each channel width bits wide) in the
  // low bits of the result; callers keep only their own WIDTH low bits.
  function automatic logic [MAX_W-1:0] ch_slice(
    input logic [MAX_BUS-1:0] bus,
    input int                 idx,
    input int                 width
  );
    logic [MAX_BUS-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Round-robin arbiter for stream_mux_nx1.
// Searches upward from ptr+1 (wrapping modulo CHANNELS) and grants the first
// requesting channel; produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_any
);

  // Priority search starting just after the last granted channel.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= CHANNELS; off++) begin
      if (!grant_any && req[(int'(ptr) + off) % CHANNELS]) begin
        grant_any = 1'b1;
        grant_idx = SEL_W'((int'(ptr) + off) % CHANNELS);
        grant[(int'(ptr) + off) % CHANNELS] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 stream multiplexer with valid/ready handshakes and a one-entry
// registered output stage.
// Optional feature macro: STREAM_MUX_RR_EN compiles in round-robin arbitration
// (mode selects fixed or round-robin). Without it only fixed select exists,
// mode is ignored and no round-robin pointer is kept.
// Supports WIDTH up to 64 and CHANNELS 2..16.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch
);

  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_ch_reg;
  logic                out_valid_reg;

  logic                accept;
  logic                transfer;
  logic [CHANNELS-1:0] fixed_grant;
  logic [CHANNELS-1:0] grant_vec;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_any;

  logic [MAX_BUS-1:0]  bus_ext;
  logic [MAX_W-1:0]    grant_word_wide;
  logic                unused_word_bits;

  // The output register can take a new word when empty or being drained.
  assign accept   = !out_valid_reg || out_ready;
  assign transfer = grant_any && accept;

  // Fixed-select decode; an out-of-range sel matches no channel.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_fixed
      assign fixed_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
    end
  endgenerate

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0]    rr_ptr_reg;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_reg),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // Mode picks between the round-robin and fixed grant in the same cycle.
  always_comb begin
    grant_vec = fixed_grant;
    grant_idx = sel;
    grant_any = |fixed_grant;
    if (mode == MODE_RR) begin
      grant_vec = rr_grant;
      grant_idx = rr_idx;
      grant_any = rr_any;
    end
  end

  // Pointer remembers the last round-robin winner; reset gives channel 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= SEL_W'(CHANNELS - 1);
    end else if (transfer && (mode == MODE_RR)) begin
      rr_ptr_reg <= grant_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  // Only fixed select is available in this build.
  always_comb begin
    grant_vec = fixed_grant;
    grant_idx = sel;
    grant_any = |fixed_grant;
  end
`endif

  // Only the granted channel sees ready, and never while reset is asserted.
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = grant_vec[gi] && accept && rst_n;
    end
  endgenerate

  // Zero-extend the input bus so the shared slice helper can pick the winner.
  always_comb begin
    bus_ext = '0;
    bus_ext[CHANNELS*WIDTH-1:0] = in_data;
  end

  assign grant_word_wide  = ch_slice(bus_ext, int'(grant_idx), WIDTH);
  assign unused_word_bits = ^grant_word_wide;

  // Output register: load on transfer, clear valid on a drain with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (transfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= grant_word_wide[WIDTH-1:0];
      out_ch_reg    <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed testbench for stream_mux_nx1 (4 channels x 4 bits).
// Round-robin checks are built when STREAM_MUX_RR_EN is defined; otherwise
// the bench checks that mode is ignored.
module tb_stream_mux_nx1;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_ch;

  int total = 0;
  int bad   = 0;

  // Channel words A=0000, B=1001, C=0011, D=1000.
  logic [3:0] ch_word [4] = '{4'b0000, 4'b1001, 4'b0011, 4'b1000};

  always #5 clk = ~clk;

  stream_mux_nx1 #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  // One line per word leaving the output register.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready)
      $display("xfer: ch=%0d data=%b", out_ch, out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    int rr_seq [5] = '{0, 1, 2, 3, 0};
    int sp_seq [3] = '{2, 0, 2};

    rst_n     = 1'b0;
    in_data   = {ch_word[3], ch_word[2], ch_word[1], ch_word[0]};
    in_valid  = 4'b1111;
    sel       = 2'd0;
    mode      = 1'b0;
    out_ready = 1'b1;

    // Reset state, with every channel valid so in_ready gating is visible.
    repeat (2) tick();
    expect_out("reset", 1'b0, 4'b0000, 2'd0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);

    rst_n = 1'b1;
    #1;

    // Fixed mode: sel steps 0..3, word appears one cycle later.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk($sformatf("fix%0d_in_ready", i), 32'(in_ready), 32'(1 << i));
      tick();
      expect_out($sformatf("fix%0d", i), 1'b1, ch_word[i], 2'(i));
    end

    // Backpressure with a word from channel 1 held for 3 cycles.
    sel = 2'd1;
    tick();
    expect_out("bp_load", 1'b1, 4'b1001, 2'd1);
    out_ready = 1'b0;
    sel       = 2'd2;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("bp_hold%0d", i), 1'b1, 4'b1001, 2'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'h0);
    end
    // Release: drain and refill from channel 2 in the same cycle.
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'b0100);
    tick();
    expect_out("bp_refill", 1'b1, 4'b0011, 2'd2);

    // Fixed sel=2 with channel 2 not valid: no grant, word drains.
    in_valid = 4'b1011;
    #1;
    chk("nogrant_in_ready", 32'(in_ready), 32'h0);
    tick();
    expect_out("nogrant_drain", 1'b0, 4'b0011, 2'd2);
    tick();
    expect_out("nogrant_idle", 1'b0, 4'b0011, 2'd2);

`ifdef STREAM_MUX_RR_EN
    // Round-robin, all valid: 0,1,2,3,0 back to back.
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'(1 << rr_seq[i]));
      tick();
      expect_out($sformatf("rr%0d", i), 1'b1, ch_word[rr_seq[i]], 2'(rr_seq[i]));
    end

    // Sparse round-robin, only channels 0 and 2 valid; pointer is at 0.
    in_valid = 4'b0101;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sp%0d_in_ready", i), 32'(in_ready), 32'(1 << sp_seq[i]));
      tick();
      expect_out($sformatf("sp%0d", i), 1'b1, ch_word[sp_seq[i]], 2'(sp_seq[i]));
    end
`else
    // Without round-robin support mode is ignored: sel still decides.
    mode     = 1'b1;
    sel      = 2'd3;
    in_valid = 4'b1111;
    #1;
    chk("modeign_in_ready", 32'(in_ready), 32'b1000);
    tick();
    expect_out("modeign", 1'b1, 4'b1000, 2'd3);
    foreach (rr_seq[i]) if (rr_seq[i] < 0) $display("unused");
    foreach (sp_seq[i]) if (sp_seq[i] < 0) $display("unused");
`endif

    // Asynchronous reset while a word is held.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("arst", 1'b0, 4'b0000, 2'd0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    tick();
    expect_out("arst_hold", 1'b0, 4'b0000, 2'd0);

    // After release the first grant goes to channel 0.
    in_valid = 4'b1111;
    sel      = 2'd0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
    tick();
    expect_out("post_rst", 1'b1, 4'b0000, 2'd0);
`ifdef STREAM_MUX_RR_EN
    chk("post_rst_next_in_ready", 32'(in_ready), 32'b0010);
    tick();
    expect_out("post_rst_next", 1'b1, 4'b1001, 2'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
